// File: rtl/decode_instruction.sv
// Decode stage: two-entry {inst, pc} skid FIFO with field extraction, jump redirect
// and post-jump input dropping. Downstream flush discards everything held.
module decode_instruction #(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int DROP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  output logic            stall_o,
  output logic            branch,
  output logic [ADDR-1:0] branch_addr,
  output logic            v_o,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [5:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [WORD-1:0] imm_o,
  output logic [ADDR-1:0] pc_o
);

  localparam int DW = (DROP < 1) ? 1 : $clog2(DROP + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WORD-1:0] inst0, inst1;
  logic [ADDR-1:0] pc0, pc1;
  logic [DW-1:0]   drop_cnt;
  logic            is_jump, accept, push, pop;

  assign stall_o = (state == TWO);
  assign v_o     = (state != EMPTY);
  assign is_jump = (inst_i[31:26] == 6'h02);
  assign accept  = v_i & ~stall_o & ~flush_i & (drop_cnt == {DW{1'b0}});
  assign push    = accept & ~is_jump;
  assign pop     = v_o & ~stall_i;

  assign opcode_o = inst0[31:26];
  assign rd_o     = inst0[25:21];
  assign rs_o     = inst0[20:16];
  assign rt_o     = inst0[15:11];
  assign imm_o    = {{(WORD-16){inst0[15]}}, inst0[15:0]};
  assign pc_o     = pc0;

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // Next occupancy; flush overrides any same-edge push or pop.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   state_next = push ? ONE : EMPTY;
        ONE: begin
          if (push && !pop)      state_next = TWO;
          else if (!push && pop) state_next = EMPTY;
          else                   state_next = ONE;
        end
        TWO:     state_next = pop ? ONE : TWO;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Entry storage; slot 0 is always the head, so push-with-pop at ONE overwrites it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst0 <= {WORD{1'b0}};
      inst1 <= {WORD{1'b0}};
      pc0   <= {ADDR{1'b0}};
      pc1   <= {ADDR{1'b0}};
    end else if (!flush_i) begin
      case (state)
        EMPTY: begin
          if (push) begin
            inst0 <= inst_i;
            pc0   <= pc_i;
          end
        end
        ONE: begin
          if (push && pop) begin
            inst0 <= inst_i;
            pc0   <= pc_i;
          end else if (push) begin
            inst1 <= inst_i;
            pc1   <= pc_i;
          end
        end
        TWO: begin
          if (pop) begin
            inst0 <= inst1;
            pc0   <= pc1;
          end
        end
        default: begin
          inst0 <= {WORD{1'b0}};
          pc0   <= {ADDR{1'b0}};
        end
      endcase
    end
  end

  // Post-jump drop counter: consumes one valid input per cycle while nonzero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= {DW{1'b0}};
    end else if (flush_i) begin
      drop_cnt <= {DW{1'b0}};
    end else if (accept && is_jump) begin
      drop_cnt <= DW'(DROP);
    end else if ((drop_cnt != {DW{1'b0}}) && v_i) begin
      drop_cnt <= drop_cnt - {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // One-cycle redirect pulse with its target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch      <= 1'b0;
      branch_addr <= {ADDR{1'b0}};
    end else begin
      branch      <= accept & is_jump;
      branch_addr <= (accept && is_jump) ? ADDR'(inst_i[15:0]) : {ADDR{1'b0}};
    end
  end

endmodule

// File: tb/tb_decode_instruction.sv
// Directed bench for decode_instruction: streaming, backpressure, jump/drop,
// flush, sign extension and mid-stream reset, with hand-computed expectations.
module tb_decode_instruction;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        stall_o, branch, v_o, stall_i, flush_i;
  logic [15:0] branch_addr, pc_o;
  logic [5:0]  opcode_o;
  logic [4:0]  rd_o, rs_o, rt_o;
  logic [31:0] imm_o;

  int checks = 0;
  int errors = 0;

  decode_instruction #(.WORD(32), .ADDR(16), .DROP(1)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_o(stall_o), .branch(branch), .branch_addr(branch_addr), .v_o(v_o),
    .stall_i(stall_i), .flush_i(flush_i), .opcode_o(opcode_o), .rd_o(rd_o),
    .rs_o(rs_o), .rt_o(rt_o), .imm_o(imm_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [15:0] pc);
    v_i    = v;
    inst_i = inst;
    pc_i   = pc;
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    #12;
    check_eq("rst_v_o", v_o, 1'b0);
    check_eq("rst_stall_o", stall_o, 1'b0);
    check_eq("rst_branch", branch, 1'b0);
    check_eq("rst_pc_o", pc_o, 16'h0);
    check_eq("rst_imm_o", imm_o, 32'h0);
    step();
    reset = 1'b1;

    // Streaming: each word presented one cycle after acceptance.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h0400_0000 | 32'(i), 16'(i));
      step();
      check_eq("stream_v_o", v_o, 1'b1);
      check_eq("stream_pc_o", pc_o, 16'(i));
      check_eq("stream_imm_o", imm_o, 32'(i));
      check_eq("stream_opcode", opcode_o, 6'h01);
      check_eq("stream_stall_o", stall_o, 1'b0);
    end
    drive(1'b0, 32'h0, 16'h0);
    step();
    check_eq("stream_drain", v_o, 1'b0);

    // Backpressure: third word held upstream, all three emerge in order.
    stall_i = 1'b1;
    drive(1'b1, 32'h0400_0010, 16'h0010);
    step();
    check_eq("bp_first_pc", pc_o, 16'h0010);
    check_eq("bp_one_stall", stall_o, 1'b0);
    drive(1'b1, 32'h0400_0011, 16'h0011);
    step();
    check_eq("bp_full_stall", stall_o, 1'b1);
    drive(1'b1, 32'h0400_0012, 16'h0012);
    step();
    check_eq("bp_held_stall", stall_o, 1'b1);
    check_eq("bp_held_head", pc_o, 16'h0010);
    stall_i = 1'b0;
    step();
    check_eq("bp_pop1_pc", pc_o, 16'h0011);
    check_eq("bp_pop1_stall", stall_o, 1'b0);
    step();
    check_eq("bp_pop2_pc", pc_o, 16'h0012);
    check_eq("bp_pop2_v", v_o, 1'b1);
    drive(1'b0, 32'h0, 16'h0);
    step();
    check_eq("bp_drain", v_o, 1'b0);

    // Jump: redirect pulse, next word dropped, jump never presented.
    drive(1'b1, 32'h0800_0012, 16'h0005);
    step();
    check_eq("jmp_branch", branch, 1'b1);
    check_eq("jmp_addr", branch_addr, 16'h0012);
    check_eq("jmp_not_enq", v_o, 1'b0);
    drive(1'b1, 32'h0400_0020, 16'h0006);
    step();
    check_eq("jmp_pulse_end", branch, 1'b0);
    check_eq("jmp_dropped", v_o, 1'b0);
    drive(1'b1, 32'h0400_0021, 16'h0007);
    step();
    check_eq("jmp_after_v", v_o, 1'b1);
    check_eq("jmp_after_pc", pc_o, 16'h0007);
    drive(1'b0, 32'h0, 16'h0);
    step();

    // Flush at count=2 with a same-edge input.
    stall_i = 1'b1;
    drive(1'b1, 32'h0400_0030, 16'h0030);
    step();
    drive(1'b1, 32'h0400_0031, 16'h0031);
    step();
    check_eq("fl_full", stall_o, 1'b1);
    flush_i = 1'b1;
    drive(1'b1, 32'h0400_0032, 16'h0032);
    step();
    check_eq("fl_v_o", v_o, 1'b0);
    check_eq("fl_stall_o", stall_o, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    step();
    check_eq("fl_input_lost", v_o, 1'b0);

    // Sign extension and field slicing.
    drive(1'b1, 32'h0400_8000, 16'h0040);
    step();
    check_eq("imm_neg", imm_o, 32'hFFFF_8000);
    drive(1'b1, 32'h0400_7FFF, 16'h0041);
    step();
    check_eq("imm_pos", imm_o, 32'h0000_7FFF);
    drive(1'b1, 32'hA871_4805, 16'h0042);
    step();
    check_eq("fld_opcode", opcode_o, 6'h2A);
    check_eq("fld_rd", rd_o, 5'd3);
    check_eq("fld_rs", rs_o, 5'd17);
    check_eq("fld_rt", rt_o, 5'd9);
    check_eq("fld_imm", imm_o, 32'h0000_4805);
    drive(1'b0, 32'h0, 16'h0);
    step();

    // Reset with a pending branch and nonzero drop counter.
    stall_i = 1'b1;
    drive(1'b1, 32'h0400_0050, 16'h0050);
    step();
    drive(1'b1, 32'h0800_0034, 16'h0051);
    step();
    check_eq("rj_branch_pre", branch, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("rj_branch", branch, 1'b0);
    check_eq("rj_addr", branch_addr, 16'h0);
    check_eq("rj_v_o", v_o, 1'b0);
    check_eq("rj_pc_o", pc_o, 16'h0);
    step();
    reset = 1'b1; stall_i = 1'b0;
    drive(1'b1, 32'h0400_0060, 16'h0060);
    step();
    check_eq("rj_accept_v", v_o, 1'b1);
    check_eq("rj_accept_pc", pc_o, 16'h0060);
    drive(1'b0, 32'h0, 16'h0);
    step();

    // Reset with count=2.
    stall_i = 1'b1;
    drive(1'b1, 32'h0400_0070, 16'h0070);
    step();
    drive(1'b1, 32'h0400_0071, 16'h0071);
    step();
    check_eq("r2_full", stall_o, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("r2_stall_o", stall_o, 1'b0);
    check_eq("r2_v_o", v_o, 1'b0);
    check_eq("r2_imm_o", imm_o, 32'h0);
    step();
    reset = 1'b1; stall_i = 1'b0;
    drive(1'b1, 32'h0400_0080, 16'h0080);
    step();
    check_eq("r2_accept_pc", pc_o, 16'h0080);
    check_eq("r2_accept_v", v_o, 1'b1);
    drive(1'b0, 32'h0, 16'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_instruction.md
DECODE_INSTRUCTION -- requirements
Module: decode_instruction

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WORD, 32, instruction width.
  ADDR, 16, instruction address width.
  DROP, 1, number of input cycles discarded after a jump redirect.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  reset  in  1  asynchronous, active-low reset.
  v_i  in  1  upstream instruction valid; connects to the fetch stage's v_o.
  inst_i  in  WORD  upstream instruction word.
  pc_i  in  ADDR  address of inst_i.
  stall_o  out  1  backpressure to fetch; connects to the fetch stage's stall_i.
  branch  out  1  one-cycle redirect pulse to fetch.
  branch_addr  out  ADDR  redirect target; valid while branch=1.
  v_o  out  1  downstream decoded-instruction valid.
  stall_i  in  1  downstream backpressure.
  flush_i  in  1  downstream redirect; discards all held instructions.
  opcode_o  out  6  inst[31:26].
  rd_o  out  5  inst[25:21].
  rs_o  out  5  inst[20:16].
  rt_o  out  5  inst[15:11].
  imm_o  out  WORD  inst[15:0] sign-extended to WORD bits.
  pc_o  out  ADDR  address of the presented instruction.

Function
REQ-003 The block SHALL hold up to 2 entries of {inst, pc} in a FIFO; its state SHALL be its count: EMPTY(0), ONE(1), or TWO(2).
REQ-004 stall_o SHALL equal (count==2), combinational from registered state only.
REQ-005 An input SHALL be accepted on a rising edge when v_i=1, stall_o=0, flush_i=0, and the drop counter is 0.
REQ-006 v_o SHALL equal (count>0); the decoded fields SHALL be driven from the head entry.
REQ-007 The head SHALL be popped on a rising edge when v_o=1 and stall_i=0.
REQ-008 Simultaneous push and pop SHALL leave count unchanged and preserve order; a push at count==1 with a pop SHALL place the new entry at the head.
REQ-009 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented on v_o after edge N when the FIFO was EMPTY.
REQ-010 A jump is opcode 6'h02. When accepted, a jump SHALL NOT be enqueued; branch SHALL be 1 for exactly the following cycle, with branch_addr = inst[15:0].
REQ-011 After a jump is accepted, the drop counter SHALL load DROP; each cycle with v_i=1 SHALL decrement it and discard the input; inputs arriving while it is nonzero SHALL NOT be accepted.
REQ-012 When flush_i=1 on an edge:
  count SHALL become 0 and the drop counter SHALL clear;
  any same-edge input and any same-edge jump SHALL be discarded (no branch pulse);
  v_o SHALL be 0 in the next cycle.
REQ-013 Pushes SHALL never occur at count==2, and pops SHALL never occur at count==0; there SHALL be no overflow or underflow.
REQ-014 Sign extension SHALL replicate inst[15] into imm_o[31:16].

Reset
REQ-015 While reset=0, the following SHALL hold asynchronously: count=0, drop counter=0, v_o=0, stall_o=0, branch=0, branch_addr=0, and all field outputs 0.
REQ-016 Reset asserted mid-operation SHALL discard all entries and any pending branch or drop; the first accept SHALL be possible on the first edge after reset=1.

Verification
REQ-017 Stream inst 0x04000001..0x04000003 with stall_i=0 -> each appears on v_o one cycle later, in order, with stall_o=0 throughout.
REQ-018 Hold stall_i=1 while pushing 3 instructions -> count reaches 2, stall_o=1, the third is held upstream; release -> all 3 emerge in order, none lost or duplicated.
REQ-019 Push 0x08000012 (jump) at pc 0x0005 -> branch=1 for one cycle with branch_addr=0x0012; the next v_i word is discarded; the jump never appears on v_o.
REQ-020 Count=2 with flush_i=1 and v_i=1 on the same edge -> v_o=0 next cycle, count=0, the input is discarded.
REQ-021 Push imm 0x8000 -> imm_o=0xFFFF8000; push imm 0x7FFF -> imm_o=0x00007FFF.
REQ-022 Assert reset=0 mid-stream with count=2 and the drop counter nonzero -> all outputs 0 immediately; after release, the first v_i is accepted.
